// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_pkg
//  Description : Shared definitions for the board I/O controller:
//                register word addresses, IRQ status bit positions and the
//                hex-to-7-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_io_pkg;

  // Register word addresses
  localparam logic [2:0] c_ADDR_DIGIT_DATA = 3'd0;
  localparam logic [2:0] c_ADDR_DIGIT_EN   = 3'd1;
  localparam logic [2:0] c_ADDR_KEY_STATE  = 3'd2;
  localparam logic [2:0] c_ADDR_SW_STATE   = 3'd3;
  localparam logic [2:0] c_ADDR_IRQ_STATUS = 3'd4;
  localparam logic [2:0] c_ADDR_IRQ_MASK   = 3'd5;

  // IRQ_STATUS / IRQ_MASK bit positions
  localparam int c_IRQ_KEY_BIT = 0;
  localparam int c_IRQ_SW_BIT  = 1;

  // Segment order is {a,b,c,d,e,f,g}; a lit segment is 1.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : io_debounce
//  Description : Single-bit sample-count debouncer. On every sample_en the
//                raw bit is compared with the stable value; DEBOUNCE_CNT
//                consecutive differing samples flip the stable value. Any
//                sample equal to the stable value restarts the count.
//  Ports       : clk       in  system clock
//                resetn    in  synchronous active-low reset
//                sample_en in  take one sample of raw this cycle
//                raw       in  synchronised input bit
//                stable    out debounced value
//  Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic sample_en,
  input  logic raw,
  output logic stable
);

  logic [3:0] cnt_q;
  logic       stable_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= 4'd0;
      stable_q <= 1'b0;
    end else if (sample_en) begin
      if (raw == stable_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_q == 4'(DEBOUNCE_CNT - 1)) begin
        // This sample is the DEBOUNCE_CNT-th consecutive difference.
        cnt_q    <= 4'd0;
        stable_q <= ~stable_q;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/board_io_scan.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_scan
//  Description : Board I/O controller. Multiplexes an N-digit 7-segment
//                display, scans an R x C key matrix and debounces switches,
//                with a small word-addressed register bus.
//                Build option BOARD_IO_IRQ_EN adds key-press / switch-change
//                interrupt status, mask and a level irq output; without it
//                IRQ_STATUS/IRQ_MASK read 0 and irq is tied low.
//  Ports       : clk, resetn          clock, synchronous active-low reset
//                reg_wr_en/reg_rd_en  bus write / read strobes
//                reg_addr, reg_wdata  word address, write data
//                reg_rdata            registered read data
//                num_csn, num_a_g     digit select (active low), segments
//                btn_key_col          key column drive (active low)
//                btn_key_row          key row sense (low = pressed, async)
//                switch               switch inputs (async)
//                irq                  level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module board_io_scan
  import board_io_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int KEY_ROWS     = 4,
  parameter int KEY_COLS     = 4,
  parameter int SW_WIDTH     = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [2:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic [NUM_DIGITS-1:0] num_csn,
  output logic [6:0]            num_a_g,
  output logic [KEY_COLS-1:0]   btn_key_col,
  input  logic [KEY_ROWS-1:0]   btn_key_row,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic                  irq
);

  localparam int c_CNT_W = $clog2(SCAN_DIV);
  localparam int c_DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_COL_W = (KEY_COLS > 1) ? $clog2(KEY_COLS) : 1;
  localparam int c_NKEY  = KEY_ROWS * KEY_COLS;

  // --------------------------------------------------------------------------
  // Prescaler and scan pointers
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_DIG_W-1:0] dig_q, dig_d;
  logic [c_COL_W-1:0] col_q, col_d;
  logic               w_tick;

  assign w_tick = (cnt_q == c_CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = w_tick ? '0 : cnt_q + 1'b1;
    dig_d = dig_q;
    col_d = col_q;
    if (w_tick) begin
      dig_d = (dig_q == c_DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      col_d = (col_q == c_COL_W'(KEY_COLS - 1))   ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      dig_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      col_q <= col_d;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   en_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
      en_q   <= '0;
    end else if (reg_wr_en) begin
      if (reg_addr == c_ADDR_DIGIT_DATA) data_q <= reg_wdata[4*NUM_DIGITS-1:0];
      if (reg_addr == c_ADDR_DIGIT_EN)   en_q   <= reg_wdata[NUM_DIGITS-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Scan outputs. Decoded from the next-state pointers so that the pads
  // change on the same edge the pointers advance (the cycle after tick).
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] csn_q, csn_d;
  logic [6:0]            seg_q, seg_d;
  logic [KEY_COLS-1:0]   colo_q, colo_d;

  always_comb begin
    csn_d  = '1;
    seg_d  = '0;
    colo_d = ~(KEY_COLS'(1) << col_d);
    if (en_q[dig_d]) begin
      csn_d = ~(NUM_DIGITS'(1) << dig_d);
      seg_d = hex_to_seg(data_q[{dig_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      csn_q  <= '1;
      seg_q  <= '0;
      colo_q <= '1;
    end else begin
      csn_q  <= csn_d;
      seg_q  <= seg_d;
      colo_q <= colo_d;
    end
  end

  assign num_csn     = csn_q;
  assign num_a_g     = seg_q;
  assign btn_key_col = colo_q;

  // --------------------------------------------------------------------------
  // Input synchronisers. Row flops reset to the idle (released) level so a
  // key can never look pressed straight out of reset.
  // --------------------------------------------------------------------------
  logic [KEY_ROWS-1:0] row_s1_q, row_s2_q;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      row_s1_q <= btn_key_row;
      row_s2_q <= row_s1_q;
      sw_s1_q  <= switch;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers. A key bit is sampled only on the tick that ends its column's
  // drive window (col_q still points at that column).
  // --------------------------------------------------------------------------
  logic [c_NKEY-1:0]   key_state;
  logic [SW_WIDTH-1:0] sw_state;

  for (genvar r = 0; r < KEY_ROWS; r++) begin : g_key_row
    for (genvar c = 0; c < KEY_COLS; c++) begin : g_key_col
      logic w_en;
      logic w_raw;
      assign w_en  = w_tick && (col_q == c_COL_W'(c));
      assign w_raw = ~row_s2_q[r];
      io_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
        .clk       (clk),
        .resetn    (resetn),
        .sample_en (w_en),
        .raw       (w_raw),
        .stable    (key_state[r*KEY_COLS+c])
      );
    end
  end

  for (genvar s = 0; s < SW_WIDTH; s++) begin : g_sw
    io_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
      .clk       (clk),
      .resetn    (resetn),
      .sample_en (w_tick),
      .raw       (sw_s2_q[s]),
      .stable    (sw_state[s])
    );
  end

  // --------------------------------------------------------------------------
  // Interrupts
  // --------------------------------------------------------------------------
`ifdef BOARD_IO_IRQ_EN
  logic [c_NKEY-1:0]   key_prev_q;
  logic [SW_WIDTH-1:0] sw_prev_q;
  logic [1:0]          irq_status_q, irq_status_d;
  logic [1:0]          irq_mask_q, irq_mask_d;
  logic [1:0]          w_set, w_clr;
  logic                irq_q;

  always_comb begin
    w_set                = '0;
    w_set[c_IRQ_KEY_BIT] = |(key_state & ~key_prev_q);
    w_set[c_IRQ_SW_BIT]  = |(sw_state ^ sw_prev_q);
    w_clr      = (reg_wr_en && reg_addr == c_ADDR_IRQ_STATUS) ? reg_wdata[1:0] : 2'b00;
    irq_mask_d = (reg_wr_en && reg_addr == c_ADDR_IRQ_MASK)   ? reg_wdata[1:0] : irq_mask_q;
    // Set is OR-ed in after the clear so a simultaneous event is never lost.
    irq_status_d = (irq_status_q & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_prev_q   <= '0;
      sw_prev_q    <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      key_prev_q   <= key_state;
      sw_prev_q    <= sw_state;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      irq_q        <= |(irq_status_d & irq_mask_d);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      c_ADDR_DIGIT_DATA: rdata_d[4*NUM_DIGITS-1:0] = data_q;
      c_ADDR_DIGIT_EN:   rdata_d[NUM_DIGITS-1:0]   = en_q;
      c_ADDR_KEY_STATE:  rdata_d[c_NKEY-1:0]       = key_state;
      c_ADDR_SW_STATE:   rdata_d[SW_WIDTH-1:0]     = sw_state;
`ifdef BOARD_IO_IRQ_EN
      c_ADDR_IRQ_STATUS: rdata_d[1:0]              = irq_status_q;
      c_ADDR_IRQ_MASK:   rdata_d[1:0]              = irq_mask_q;
`endif
      default:           rdata_d                   = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (reg_rd_en) begin
      rdata_q <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;

endmodule
`default_nettype wire
